fetch_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_skid.sv | 35 +++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: data width, fetch FSM states, fetch packet.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction memory port, decode handshake and execute redirect.
interface fetch_unit_if;
    import mips_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_data;
    logic              dec_ready;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] inst_pc;
    logic              fault;

    modport master (
        output imem_addr, inst_valid, inst, inst_pc, fault,
        input  imem_data, dec_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, inst_valid, inst, inst_pc, fault,
        output imem_data, dec_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a memory word that decode could not take.
module fetch_skid
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_clear,
    input  logic       i_flush,
    input  fetch_pkt_t i_pkt,
    output logic       o_valid,
    output fetch_pkt_t o_pkt
);

    logic       r_valid;
    fetch_pkt_t r_pkt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pkt   <= i_pkt;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pkt   = r_pkt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, pending-read tracking over a 1-cycle registered memory, redirect, range fault.
// state    | meaning
// FS_IDLE  | reset state, first read not yet issued
// FS_FETCH | issuing reads and delivering words to decode
// FS_FAULT | PC left the legal range; no reads until redirect or reset
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MEM_SIZE  = 64,
    parameter logic [WORD_W-1:0] RESET_PC  = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);

    localparam logic [WORD_W-1:0] LP_MEM_SIZE = WORD_W'(MEM_SIZE);

    fetch_state_t      r_state;
    logic [WORD_W-1:0] r_pc;
    logic              r_pend_valid;
    logic [WORD_W-1:0] r_pend_pc;
    logic              r_fault;

    logic       w_skid_valid;
    fetch_pkt_t w_skid_pkt;
    fetch_pkt_t w_cap_pkt;
    logic       w_inst_valid;
    logic       w_stall_cap;
    logic       w_skid_clear;
    logic       w_pc_ok;

    assign w_inst_valid = w_skid_valid | r_pend_valid;
    assign w_stall_cap  = r_pend_valid & ~bus.dec_ready & ~w_skid_valid;
    assign w_skid_clear = w_skid_valid & bus.dec_ready;
    assign w_pc_ok      = (r_pc < LP_MEM_SIZE);
    assign w_cap_pkt    = '{inst: bus.imem_data, pc: r_pend_pc};

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_stall_cap),
        .i_clear (w_skid_clear),
        .i_flush (bus.redirect_valid),
        .i_pkt   (w_cap_pkt),
        .o_valid (w_skid_valid),
        .o_pkt   (w_skid_pkt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FS_IDLE;
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_fault      <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_state      <= FS_FETCH;
            r_pc         <= bus.redirect_pc;
            r_pend_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                FS_IDLE: r_state <= FS_FETCH;
                FS_FETCH: begin
                    if (w_skid_valid) begin
                        // pend_pc == pc while the skid is full; step pc as it drains so the
                        // pending word is not re-issued on resume
                        if (bus.dec_ready) r_pc <= r_pc + 1'b1;
                    end else if (w_stall_cap) begin
                        r_pend_pc <= r_pc;
                        if (w_pc_ok) begin
                            r_pend_valid <= 1'b1;
                        end else begin
                            r_pend_valid <= 1'b0;
                            r_state      <= FS_FAULT;
                            r_fault      <= 1'b1;
                        end
                    end else if (w_pc_ok) begin
                        r_pend_pc    <= r_pc;
                        r_pend_valid <= 1'b1;
                        r_pc         <= r_pc + 1'b1;
                    end else begin
                        r_pend_valid <= 1'b0;
                        r_state      <= FS_FAULT;
                        r_fault      <= 1'b1;
                    end
                end
                FS_FAULT: begin
                    r_pend_valid <= 1'b0;
                    r_fault      <= 1'b1;
                end
                default: r_state <= FS_IDLE;
            endcase
        end
    end

    assign bus.imem_addr  = r_pc + BASE_ADDR;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst       = w_skid_valid ? w_skid_pkt.inst :
                            (r_pend_valid ? bus.imem_data : '0);
    assign bus.inst_pc    = w_skid_valid ? w_skid_pkt.pc :
                            (r_pend_valid ? r_pend_pc : '0);
    assign bus.fault      = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 64-word unit and an 8-word unit, each with a registered memory model.
module tb_fetch_unit;
    import mips_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_unit_if bus();
    fetch_unit_if bus8();

    fetch_unit #(.BASE_ADDR(32'd0), .MEM_SIZE(64), .RESET_PC(32'd0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    fetch_unit #(.BASE_ADDR(32'd0), .MEM_SIZE(8), .RESET_PC(32'd0)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.master)
    );

    // mem[i] = i + 0x100, one-cycle registered read
    always @(posedge clk) begin
        bus.imem_data  <= bus.imem_addr + 32'h100;
        bus8.imem_data <= bus8.imem_addr + 32'h100;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic [31:0] ep);
        chk({tag, "_valid"}, 32'(v), 32'd1);
        chk({tag, "_pc"}, p, ep);
        chk({tag, "_inst"}, i, ep + 32'h100);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.dec_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus8.dec_ready      = 1'b1;
        bus8.redirect_valid = 1'b0;
        bus8.redirect_pc    = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);

        reset = 1'b0;
        chk("c1_valid", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        chk("c2_valid", 32'(bus.inst_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_pkt($sformatf("stream%0d", k), bus.inst_valid, bus.inst, bus.inst_pc, 32'(k));
        end

        // decode stalls for three cycles on pc 4
        @(negedge clk);
        chk_pkt("stallA", bus.inst_valid, bus.inst, bus.inst_pc, 32'd4);
        bus.dec_ready = 1'b0;
        @(negedge clk);
        chk_pkt("stallB", bus.inst_valid, bus.inst, bus.inst_pc, 32'd4);
        @(negedge clk);
        chk_pkt("stallC", bus.inst_valid, bus.inst, bus.inst_pc, 32'd4);
        @(negedge clk);
        chk_pkt("stallD", bus.inst_valid, bus.inst, bus.inst_pc, 32'd4);
        bus.dec_ready = 1'b1;
        @(negedge clk);
        chk_pkt("resume5", bus.inst_valid, bus.inst, bus.inst_pc, 32'd5);
        @(negedge clk);
        chk_pkt("resume6", bus.inst_valid, bus.inst, bus.inst_pc, 32'd6);

        // redirect to 20 while streaming
        @(negedge clk);
        chk_pkt("redir_n", bus.inst_valid, bus.inst, bus.inst_pc, 32'd7);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd20;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("redir_bubble", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        chk_pkt("redir_tgt", bus.inst_valid, bus.inst, bus.inst_pc, 32'd20);
        @(negedge clk);
        chk_pkt("redir_tgt1", bus.inst_valid, bus.inst, bus.inst_pc, 32'd21);

        // redirect while the skid buffer is full
        @(negedge clk);
        chk_pkt("skid_in", bus.inst_valid, bus.inst, bus.inst_pc, 32'd22);
        bus.dec_ready = 1'b0;
        @(negedge clk);
        chk_pkt("skid_full", bus.inst_valid, bus.inst, bus.inst_pc, 32'd22);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.dec_ready      = 1'b1;
        chk("skid_redir_bubble", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        chk_pkt("skid_redir_tgt", bus.inst_valid, bus.inst, bus.inst_pc, 32'd40);

        // asynchronous reset with the skid buffer full
        @(negedge clk);
        chk_pkt("rst_skid_in", bus.inst_valid, bus.inst, bus.inst_pc, 32'd41);
        bus.dec_ready = 1'b0;
        @(negedge clk);
        chk_pkt("rst_skid_full", bus.inst_valid, bus.inst, bus.inst_pc, 32'd41);
        chk("f8_before_rst", 32'(bus8.fault), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_fault", 32'(bus.fault), 32'd0);
        chk("arst_addr", bus.imem_addr, 32'd0);
        chk("arst_f8_fault", 32'(bus8.fault), 32'd0);
        bus.dec_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rs_c2_valid", 32'(bus.inst_valid), 32'd0);
        chk("rs_c2_valid8", 32'(bus8.inst_valid), 32'd0);
        @(negedge clk);
        chk_pkt("rs_first", bus.inst_valid, bus.inst, bus.inst_pc, 32'd0);
        chk_pkt("m8_0", bus8.inst_valid, bus8.inst, bus8.inst_pc, 32'd0);

        // 8-word memory: run off the end, then redirect back in range
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk_pkt($sformatf("m8_%0d", k), bus8.inst_valid, bus8.inst, bus8.inst_pc, 32'(k));
            chk("m8_nofault", 32'(bus8.fault), 32'd0);
        end
        @(negedge clk);
        chk("m8_end_valid", 32'(bus8.inst_valid), 32'd0);
        chk("m8_end_fault", 32'(bus8.fault), 32'd1);
        chk_pkt("main8", bus.inst_valid, bus.inst, bus.inst_pc, 32'd8);
        @(negedge clk);
        chk("m8_hold_valid", 32'(bus8.inst_valid), 32'd0);
        chk("m8_hold_fault", 32'(bus8.fault), 32'd1);
        bus8.redirect_valid = 1'b1;
        bus8.redirect_pc    = 32'd2;
        @(negedge clk);
        bus8.redirect_valid = 1'b0;
        chk("m8_redir_fault", 32'(bus8.fault), 32'd0);
        chk("m8_redir_bubble", 32'(bus8.inst_valid), 32'd0);
        @(negedge clk);
        chk_pkt("m8_redir_tgt", bus8.inst_valid, bus8.inst, bus8.inst_pc, 32'd2);
        @(negedge clk);
        chk_pkt("m8_redir_tgt1", bus8.inst_valid, bus8.inst, bus8.inst_pc, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
